// File: rtl/mcash_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mcash_pkg : shared request-path types and widths for the cross bar     |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
package mcash_pkg;

    localparam int c_CH_ID_W = 2;
    localparam int c_ADDR_W  = 28;
    localparam int c_WBID_W  = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_EVICT = 2'd2,
        OP_FLUSH = 2'd3
    } opcode_t;

endpackage
`default_nettype wire

// File: rtl/xbar_bank_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting after last grant  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int CH_ID_W = 2
) (
    input  logic [NUM_CH-1:0]  i_req,
    input  logic [CH_ID_W-1:0] i_last_grant,
    output logic [NUM_CH-1:0]  o_grant,
    output logic [CH_ID_W-1:0] o_grant_idx,
    output logic               o_any_grant
);

    always_comb begin
        logic [CH_ID_W-1:0] w_idx;
        w_idx       = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        // Offsets 1..NUM_CH visit every channel once; the previous winner comes last.
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_ID_W'((int'(i_last_grant) + k) % NUM_CH);
            if (!o_any_grant && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_any_grant    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbar_bank_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | xbar_bank_arbiter : round-robin share of one bank HTU port among       |
// | channels, registered output slice. Option: XBAR_BANK_ARB_PERF_EN       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module xbar_bank_arbiter
    import mcash_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int CH_ID_W = c_CH_ID_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int WBID_W  = c_WBID_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          ch_req_valid_i,
    output logic [NUM_CH-1:0]          ch_req_ready_o,
    input  logic [NUM_CH*2-1:0]        ch_req_opcode_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i,
    input  logic [NUM_CH*WBID_W-1:0]   ch_req_wbid_i,
    output logic                       htu_valid_o,
    input  logic                       htu_ready_i,
    output logic [CH_ID_W-1:0]         htu_ch_id_o,
    output logic [1:0]                 htu_opcode_o,
    output logic [ADDR_W-1:0]          htu_addr_o,
`ifdef XBAR_BANK_ARB_PERF_EN
    output logic [NUM_CH*16-1:0]       perf_grant_cnt_o,
    output logic [15:0]                perf_stall_cnt_o,
`endif
    output logic [WBID_W-1:0]          htu_wbid_o
);

    localparam logic [CH_ID_W-1:0] c_LAST_RST = CH_ID_W'(NUM_CH - 1);

    logic                r_htu_valid;
    logic [CH_ID_W-1:0]  r_htu_ch_id;
    opcode_t             r_htu_opcode;
    logic [ADDR_W-1:0]   r_htu_addr;
    logic [WBID_W-1:0]   r_htu_wbid;
    logic [CH_ID_W-1:0]  r_last_grant;

    logic [NUM_CH-1:0]   w_grant;
    logic [CH_ID_W-1:0]  w_grant_idx;
    logic                w_any_grant;
    logic                w_slot_free;
    logic                w_fire;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_ID_W (CH_ID_W)
    ) u_rr (
        .i_req        (ch_req_valid_i),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_grant  (w_any_grant)
    );

    assign w_slot_free    = !r_htu_valid || htu_ready_i;
    assign w_fire         = rst_i && w_slot_free && w_any_grant;
    assign ch_req_ready_o = w_fire ? w_grant : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_htu_valid  <= 1'b0;
            r_htu_ch_id  <= '0;
            r_htu_opcode <= OP_READ;
            r_htu_addr   <= '0;
            r_htu_wbid   <= '0;
            r_last_grant <= c_LAST_RST;
        end else if (w_slot_free) begin
            r_htu_valid <= w_any_grant;
            if (w_any_grant) begin
                r_htu_ch_id  <= w_grant_idx;
                r_htu_opcode <= opcode_t'(ch_req_opcode_i[w_grant_idx*2 +: 2]);
                r_htu_addr   <= ch_req_addr_i[w_grant_idx*ADDR_W +: ADDR_W];
                r_htu_wbid   <= ch_req_wbid_i[w_grant_idx*WBID_W +: WBID_W];
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign htu_valid_o  = r_htu_valid;
    assign htu_ch_id_o  = r_htu_ch_id;
    assign htu_opcode_o = r_htu_opcode;
    assign htu_addr_o   = r_htu_addr;
    assign htu_wbid_o   = r_htu_wbid;

`ifdef XBAR_BANK_ARB_PERF_EN
    logic [15:0] r_stall_cnt;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_perf_grant
            logic [15:0] r_grant_cnt;
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    r_grant_cnt <= '0;
                end else if (ch_req_ready_o[c] && ch_req_valid_i[c] && r_grant_cnt != 16'hFFFF) begin
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                end
            end
            assign perf_grant_cnt_o[c*16 +: 16] = r_grant_cnt;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (r_htu_valid && !htu_ready_i && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbar_bank_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_xbar_bank_arbiter : directed vectors, queue scoreboard on HTU side  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_xbar_bank_arbiter;

    localparam int NUM_CH = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NUM_CH-1:0]    ch_req_valid_i;
    logic [NUM_CH-1:0]    ch_req_ready_o;
    logic [NUM_CH*2-1:0]  ch_req_opcode_i;
    logic [NUM_CH*28-1:0] ch_req_addr_i;
    logic [NUM_CH*8-1:0]  ch_req_wbid_i;
    logic                 htu_valid_o;
    logic                 htu_ready_i;
    logic [1:0]           htu_ch_id_o;
    logic [1:0]           htu_opcode_o;
    logic [27:0]          htu_addr_o;
    logic [7:0]           htu_wbid_o;
`ifdef XBAR_BANK_ARB_PERF_EN
    logic [NUM_CH*16-1:0] perf_grant_cnt_o;
    logic [15:0]          perf_stall_cnt_o;
`endif

    xbar_bank_arbiter #(.NUM_CH(NUM_CH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ch_req_valid_i  (ch_req_valid_i),
        .ch_req_ready_o  (ch_req_ready_o),
        .ch_req_opcode_i (ch_req_opcode_i),
        .ch_req_addr_i   (ch_req_addr_i),
        .ch_req_wbid_i   (ch_req_wbid_i),
        .htu_valid_o     (htu_valid_o),
        .htu_ready_i     (htu_ready_i),
        .htu_ch_id_o     (htu_ch_id_o),
        .htu_opcode_o    (htu_opcode_o),
        .htu_addr_o      (htu_addr_o),
`ifdef XBAR_BANK_ARB_PERF_EN
        .perf_grant_cnt_o(perf_grant_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .htu_wbid_o      (htu_wbid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  id;
        logic [1:0]  op;
        logic [27:0] addr;
        logic [7:0]  wbid;
        time         t;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          sb_en  = 1'b1;
    logic [1:0]  t_op   [NUM_CH];
    logic [27:0] t_addr [NUM_CH];
    logic [7:0]  t_wbid [NUM_CH];

    task automatic pack();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_req_opcode_i[c*2 +: 2]  = t_op[c];
            ch_req_addr_i[c*28 +: 28]  = t_addr[c];
            ch_req_wbid_i[c*8 +: 8]    = t_wbid[c];
        end
    endtask

    task automatic set_payload(input int seed);
        for (int c = 0; c < NUM_CH; c++) begin
            t_op[c]   = 2'((seed + c) % 4);
            t_addr[c] = 28'h0A00000 + 28'(seed * 16 + c);
            t_wbid[c] = 8'(seed * 8 + c + 1);
        end
    endtask

    // Drive one cycle, check the grant against the hand-computed one, log the expected HTU request.
    task automatic step(input logic [2:0] v, input logic hr, input logic [2:0] exp_rdy, input string nm);
        exp_t e;
        ch_req_valid_i = v;
        htu_ready_i    = hr;
        pack();
        @(negedge clk_i);
        checks++;
        if (ch_req_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL %s ready: got %b expected %b", nm, ch_req_ready_o, exp_rdy);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (exp_rdy[c]) begin
                e.id = 2'(c); e.op = t_op[c]; e.addr = t_addr[c]; e.wbid = t_wbid[c]; e.t = $time;
                sb_q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_bit(input logic act, input logic exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Every valid HTU cycle (including stalls) must present the oldest outstanding request.
    always @(negedge clk_i) begin
        if (rst_i && sb_en) begin
            if (htu_valid_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL htu_unexpected: got valid=1 expected no request");
                end else begin
                    if (htu_ch_id_o !== sb_q[0].id || htu_opcode_o !== sb_q[0].op ||
                        htu_addr_o !== sb_q[0].addr || htu_wbid_o !== sb_q[0].wbid) begin
                        errors++;
                        $display("FAIL htu_payload: got id=%0d op=%0d addr=%h wbid=%h expected id=%0d op=%0d addr=%h wbid=%h",
                                 htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbid_o,
                                 sb_q[0].id, sb_q[0].op, sb_q[0].addr, sb_q[0].wbid);
                    end
                    if (htu_ready_i) void'(sb_q.pop_front());
                end
            end else if (sb_q.size() != 0 && sb_q[0].t < $time) begin
                checks++;
                errors++;
                $display("FAIL htu_missing: got valid=0 expected id=%0d", sb_q[0].id);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        rst_i          = 1'b0;
        ch_req_valid_i = '0;
        htu_ready_i    = 1'b1;
        set_payload(0);
        pack();
        @(posedge clk_i);
        #1;

        // Reset held with every channel requesting.
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 1'b1, 3'b000, "rst_hold");
            check_bit(htu_valid_o, 1'b0, "rst_htu_valid");
        end
        rst_i = 1'b1;

        // Round-robin with HTU always ready: first grant ch0, then rotate.
        step(3'b111, 1'b1, 3'b001, "rr0");
        for (int i = 1; i <= 6; i++) begin
            logic [2:0] exp_oh;
            exp_oh = 3'b001 << (i % 3);
            set_payload(i);
            step(3'b111, 1'b1, exp_oh, "rr");
        end
        step(3'b000, 1'b1, 3'b000, "rr_idle");

        // Lone ch2 request with a known payload.
        t_addr[2] = 28'h0ABCDEF;
        t_wbid[2] = 8'h5A;
        t_op[2]   = 2'd1;
        step(3'b100, 1'b1, 3'b100, "ch2_only");
        step(3'b000, 1'b1, 3'b000, "ch2_idle");

        // Stall: ch0 occupies the slot for 5 cycles, ch1 issues in the drain cycle.
        set_payload(20);
        step(3'b001, 1'b0, 3'b001, "stall_load");
        for (int i = 0; i < 5; i++) begin
            step(3'b011, 1'b0, 3'b000, "stall_hold");
            check_bit(htu_valid_o, 1'b1, "stall_valid");
        end
        step(3'b011, 1'b1, 3'b010, "stall_drain");
        step(3'b000, 1'b1, 3'b000, "stall_idle");

        // Reset while a stalled request is in flight.
        set_payload(30);
        step(3'b001, 1'b0, 3'b001, "mid_load");
        check_bit(htu_valid_o, 1'b1, "mid_valid_before");
        rst_i = 1'b0;
        step(3'b111, 1'b0, 3'b000, "mid_rst");
        check_bit(htu_valid_o, 1'b0, "mid_valid_after");
        sb_q.delete();
        rst_i = 1'b1;
        step(3'b111, 1'b1, 3'b001, "post_rst_ch0");
        step(3'b010, 1'b1, 3'b010, "post_rst_ch1");
        step(3'b000, 1'b1, 3'b000, "post_idle");
        step(3'b000, 1'b1, 3'b000, "post_idle2");

`ifdef XBAR_BANK_ARB_PERF_EN
        // Saturation: 70000 back-to-back ch0 fires.
        sb_en = 1'b0;
        ch_req_valid_i = 3'b001;
        htu_ready_i    = 1'b1;
        repeat (70000) @(posedge clk_i);
        #1;
        ch_req_valid_i = 3'b000;
        repeat (3) @(posedge clk_i);
        #1;
        sb_en = 1'b1;
        checks++;
        if (perf_grant_cnt_o[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_grant0: got %h expected ffff", perf_grant_cnt_o[15:0]);
        end
        checks++;
        if (perf_grant_cnt_o[31:16] !== 16'd1) begin
            errors++;
            $display("FAIL perf_grant1: got %h expected 0001", perf_grant_cnt_o[31:16]);
        end
        checks++;
        if (perf_grant_cnt_o[47:32] !== 16'd0) begin
            errors++;
            $display("FAIL perf_grant2: got %h expected 0000", perf_grant_cnt_o[47:32]);
        end
        checks++;
        if (perf_stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL perf_stall: got %h expected 0000", perf_stall_cnt_o);
        end
`endif

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
